// File: rtl/mips_lsu_pkg.sv
// rtl/mips_lsu_pkg.sv - shared types and helpers for the MIPS load/store unit
package mips_lsu_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LBU = 3'd1,
    LH  = 3'd2,
    LHU = 3'd3,
    LW  = 3'd4,
    SB  = 3'd5,
    SH  = 3'd6,
    SW  = 3'd7
  } lsu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_ERR    = 2'd3
  } lsu_state_t;

  function automatic logic op_is_store(lsu_op_t op);
    return op inside {SB, SH, SW};
  endfunction

  // All eight encodings are in use today; a future remap that frees an
  // encoding only needs to drop it from this list to get the no-access path.
  function automatic logic op_is_known(lsu_op_t op);
    case (op)
      LB, LBU, LH, LHU, LW, SB, SH, SW: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_lsu_if.sv
// rtl/mips_lsu_if.sv - word-addressed data memory bus between the LSU and memory
interface mips_lsu_if;

  logic        mem_req;
  logic [29:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [3:0]  mem_write_en;
  logic        mem_ready;
  logic [31:0] mem_data_out;
  logic        mem_excpt;

  modport master (
    output mem_req, mem_addr, mem_data_in, mem_write_en,
    input  mem_ready, mem_data_out, mem_excpt
  );

  modport slave (
    input  mem_req, mem_addr, mem_data_in, mem_write_en,
    output mem_ready, mem_data_out, mem_excpt
  );

endinterface

// File: rtl/mips_lsu_align.sv
// rtl/mips_lsu_align.sv - store lane/mask generation and load extract/extend
module mips_lsu_align
  import mips_lsu_pkg::*;
(
  input  lsu_op_t     op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [31:0] store_data,
  output logic [3:0]  store_mask,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Pick the addressed byte and halfword out of the little-endian read word
  always_comb begin
    rbyte = rword[7:0];
    case (addr_lo)
      2'd0:    rbyte = rword[7:0];
      2'd1:    rbyte = rword[15:8];
      2'd2:    rbyte = rword[23:16];
      default: rbyte = rword[31:24];
    endcase
    rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];
  end

  // Per-op lane replication, byte mask, load extension and alignment check
  always_comb begin
    store_data = '0;
    store_mask = '0;
    load_data  = '0;
    misaligned = 1'b0;
    case (op)
      LB:  load_data = {{24{rbyte[7]}}, rbyte};
      LBU: load_data = {24'b0, rbyte};
      LH: begin
        misaligned = addr_lo[0];
        load_data  = {{16{rhalf[15]}}, rhalf};
      end
      LHU: begin
        misaligned = addr_lo[0];
        load_data  = {16'b0, rhalf};
      end
      LW: begin
        misaligned = |addr_lo;
        load_data  = rword;
      end
      SB: begin
        store_data = {4{wdata[7:0]}};
        store_mask = 4'b0001 << addr_lo;
      end
      SH: begin
        misaligned = addr_lo[0];
        store_data = {2{wdata[15:0]}};
        store_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      SW: begin
        misaligned = |addr_lo;
        store_data = wdata;
        store_mask = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_lsu.sv
// rtl/mips_lsu.sv - load/store unit: request latch, access FSM, timeout and exceptions
module mips_lsu
  import mips_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        lsu_valid,
  input  logic [2:0]  lsu_op,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_stall,
  output logic        lsu_done,
  output logic [31:0] lsu_rdata,
  output logic        lsu_adel,
  output logic        lsu_ades,
  output logic        lsu_dbe,
  output logic [31:0] lsu_bad_addr,
  mips_lsu_if.master  mem
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  lsu_state_t       state_q, state_d;
  lsu_op_t          in_op, op_q, align_op;
  logic [31:0]      addr_q, wdata_q, rdata_q, bad_addr_q;
  logic             adel_q, ades_q, dbe_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       align_addr_lo;
  logic [31:0]      store_data, load_data;
  logic [3:0]       store_mask;
  logic             misaligned, in_access, timeout_hit, bus_error;

  assign in_op     = lsu_op_t'(lsu_op);
  assign in_access = (state_q == ST_ACCESS);

  // In IDLE the alignment check looks at the incoming request; afterwards
  // everything is driven from the latched copy so the bus stays stable.
  assign align_op      = (state_q == ST_IDLE) ? in_op : op_q;
  assign align_addr_lo = (state_q == ST_IDLE) ? lsu_addr[1:0] : addr_q[1:0];

  mips_lsu_align u_align (
    .op         (align_op),
    .addr_lo    (align_addr_lo),
    .wdata      (wdata_q),
    .rword      (mem.mem_data_out),
    .store_data (store_data),
    .store_mask (store_mask),
    .load_data  (load_data),
    .misaligned (misaligned)
  );

  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  // A memory exception beats a same-cycle ready; a late ready beats the timeout.
  assign bus_error   = mem.mem_excpt || (!mem.mem_ready && timeout_hit);

  // State register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (lsu_valid) begin
          if (!op_is_known(in_op)) state_d = ST_RESP;
          else if (misaligned)     state_d = ST_ERR;
          else                     state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (mem.mem_excpt || mem.mem_ready || timeout_hit) state_d = ST_RESP;
      end
      ST_RESP, ST_ERR: state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  // Request latch, response capture, exception flags and timeout counter
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      op_q       <= LB;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      adel_q     <= 1'b0;
      ades_q     <= 1'b0;
      dbe_q      <= 1'b0;
      bad_addr_q <= '0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (lsu_valid) begin
            op_q       <= in_op;
            addr_q     <= lsu_addr;
            wdata_q    <= lsu_wdata;
            rdata_q    <= '0;
            adel_q     <= 1'b0;
            ades_q     <= 1'b0;
            dbe_q      <= 1'b0;
            bad_addr_q <= '0;
            cnt_q      <= '0;
            if (op_is_known(in_op) && misaligned) begin
              adel_q     <= !op_is_store(in_op);
              ades_q     <= op_is_store(in_op);
              bad_addr_q <= lsu_addr;
            end
          end
        end
        ST_ACCESS: begin
          if (bus_error) begin
            dbe_q      <= 1'b1;
            bad_addr_q <= addr_q;
          end else if (mem.mem_ready && !op_is_store(op_q)) begin
            rdata_q <= load_data;
          end
          if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign lsu_done     = (state_q == ST_RESP) || (state_q == ST_ERR);
  assign lsu_stall    = lsu_valid & ~lsu_done;
  assign lsu_rdata    = lsu_done ? rdata_q : '0;
  assign lsu_adel     = lsu_done & adel_q;
  assign lsu_ades     = lsu_done & ades_q;
  assign lsu_dbe      = lsu_done & dbe_q;
  assign lsu_bad_addr = bad_addr_q;

  assign mem.mem_req      = in_access;
  assign mem.mem_addr     = addr_q[31:2];
  assign mem.mem_data_in  = in_access ? store_data : '0;
  assign mem.mem_write_en = (in_access && op_is_store(op_q)) ? store_mask : 4'b0000;

endmodule

// File: tb/tb_mips_lsu.sv
// tb/tb_mips_lsu.sv - randomized self-checking bench for mips_lsu
module tb_mips_lsu;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        lsu_valid;
  logic [2:0]  lsu_op;
  logic [31:0] lsu_addr, lsu_wdata;
  logic        lsu_stall, lsu_done;
  logic [31:0] lsu_rdata;
  logic        lsu_adel, lsu_ades, lsu_dbe;
  logic [31:0] lsu_bad_addr;

  int checks = 0;
  int errors = 0;

  mips_lsu_if mem_bus ();

  mips_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .lsu_valid    (lsu_valid),
    .lsu_op       (lsu_op),
    .lsu_addr     (lsu_addr),
    .lsu_wdata    (lsu_wdata),
    .lsu_stall    (lsu_stall),
    .lsu_done     (lsu_done),
    .lsu_rdata    (lsu_rdata),
    .lsu_adel     (lsu_adel),
    .lsu_ades     (lsu_ades),
    .lsu_dbe      (lsu_dbe),
    .lsu_bad_addr (lsu_bad_addr),
    .mem          (mem_bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference model: ops 0..4 are loads LB,LBU,LH,LHU,LW; 5..7 stores SB,SH,SW
  function automatic bit m_store(int op);
    return op >= 5;
  endfunction

  function automatic bit m_misal(int op, logic [31:0] a);
    case (op)
      2, 3, 6: return (a % 2) != 0;
      4, 7:    return (a % 4) != 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_load(int op, logic [31:0] a, logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
    case (op)
      0:       return (b >= 128) ? b - 32'd256 : b;
      1:       return b;
      2:       return (h >= 32768) ? h - 32'd65536 : h;
      3:       return h;
      4:       return w;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_mask(int op, logic [31:0] a);
    case (op)
      5:       return 32'd1 << (a % 4);
      6:       return 32'd3 << (2 * ((a % 4) / 2));
      7:       return 32'd15;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(int op, logic [31:0] d);
    case (op)
      5:       return (d & 32'hFF) * 32'h01010101;
      6:       return (d & 32'hFFFF) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  // One core request; memory answers after `waits` access cycles (>= TO never answers)
  task automatic run_txn(input string nm, input int op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rword,
                         input int waits, input bit excpt);
    bit mis, exp_dbe, seen;
    int exp_done, acc;
    mis      = m_misal(op, addr);
    exp_dbe  = !mis && (excpt || waits >= TO);
    exp_done = mis ? 1 : ((waits >= TO) ? TO + 1 : waits + 2);
    seen     = 1'b0;
    acc      = 0;
    @(posedge clk); #1;
    lsu_valid = 1'b1;
    lsu_op    = op[2:0];
    lsu_addr  = addr;
    lsu_wdata = wd;
    for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
      @(negedge clk);
      if (cyc == 0) check_eq({nm, ":stall"}, lsu_stall, 1);
      mem_bus.mem_ready    = 1'b0;
      mem_bus.mem_excpt    = 1'b0;
      mem_bus.mem_data_out = $urandom;
      if (mem_bus.mem_req) begin
        check_eq({nm, ":mem_addr"}, {2'b00, mem_bus.mem_addr}, addr >> 2);
        check_eq({nm, ":mask"}, mem_bus.mem_write_en, m_mask(op, addr));
        if (m_store(op)) check_eq({nm, ":wdata"}, mem_bus.mem_data_in, m_wdata(op, wd));
        if (acc == waits) begin
          mem_bus.mem_ready    = 1'b1;
          mem_bus.mem_excpt    = excpt;
          mem_bus.mem_data_out = rword;
        end
        acc++;
      end
      if (lsu_done) begin
        seen = 1'b1;
        check_eq({nm, ":latency"}, cyc, exp_done);
        check_eq({nm, ":adel"}, lsu_adel, mis && !m_store(op));
        check_eq({nm, ":ades"}, lsu_ades, mis && m_store(op));
        check_eq({nm, ":dbe"}, lsu_dbe, exp_dbe);
        check_eq({nm, ":req_at_done"}, mem_bus.mem_req, 0);
        check_eq({nm, ":stall_at_done"}, lsu_stall, 0);
        if (mis) check_eq({nm, ":no_access"}, acc, 0);
        if (!mis && !exp_dbe && !m_store(op))
          check_eq({nm, ":rdata"}, lsu_rdata, m_load(op, addr, rword));
        if (mis || exp_dbe) check_eq({nm, ":bad_addr"}, lsu_bad_addr, addr);
        lsu_valid = 1'b0;
      end
    end
    check_eq({nm, ":done_seen"}, seen, 1);
    lsu_valid         = 1'b0;
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_excpt = 1'b0;
  endtask

  // SH whose access is cut short by an asynchronous reset in its second wait cycle
  task automatic reset_mid_access();
    int acc;
    bit hit, done_after;
    acc        = 0;
    hit        = 1'b0;
    done_after = 1'b0;
    @(posedge clk); #1;
    lsu_valid = 1'b1;
    lsu_op    = 3'd6;
    lsu_addr  = 32'h10000002;
    lsu_wdata = 32'h00001234;
    for (int cyc = 0; cyc < 10 && !hit; cyc++) begin
      @(negedge clk);
      mem_bus.mem_ready = 1'b0;
      if (mem_bus.mem_req) begin
        acc++;
        if (acc == 1) check_eq("rst:mask_before", mem_bus.mem_write_en, 32'hC);
        if (acc == 2) begin
          hit   = 1'b1;
          rst_b = 1'b0;
          #1;
          check_eq("rst:mem_req", mem_bus.mem_req, 0);
          check_eq("rst:mask", mem_bus.mem_write_en, 0);
          check_eq("rst:done", lsu_done, 0);
          #1;
          lsu_valid = 1'b0;
          rst_b     = 1'b1;
        end
      end
    end
    check_eq("rst:reached", hit, 1);
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      if (lsu_done || mem_bus.mem_req) done_after = 1'b1;
    end
    check_eq("rst:idle_after", done_after, 0);
  endtask

  initial begin
    int op, waits;
    bit excpt;
    logic [31:0] addr;
    rst_b                = 1'b0;
    lsu_valid            = 1'b0;
    lsu_op               = 3'd0;
    lsu_addr             = '0;
    lsu_wdata            = '0;
    mem_bus.mem_ready    = 1'b0;
    mem_bus.mem_excpt    = 1'b0;
    mem_bus.mem_data_out = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset:done", lsu_done, 0);
    check_eq("reset:stall", lsu_stall, 0);
    check_eq("reset:mem_req", mem_bus.mem_req, 0);
    check_eq("reset:mask", mem_bus.mem_write_en, 0);
    check_eq("reset:mem_addr", {2'b00, mem_bus.mem_addr}, 0);
    check_eq("reset:rdata", lsu_rdata, 0);
    check_eq("reset:flags", {lsu_adel, lsu_ades, lsu_dbe}, 0);
    check_eq("reset:bad_addr", lsu_bad_addr, 0);
    rst_b = 1'b1;

    run_txn("sb",       5, 32'h10000003, 32'h000000A5, 32'h0,        0,  1'b0);
    run_txn("lb",       0, 32'h10000002, 32'h0,        32'h00800000, 0,  1'b0);
    run_txn("lbu",      1, 32'h10000002, 32'h0,        32'h00800000, 0,  1'b0);
    run_txn("lw_mis",   4, 32'h10000006, 32'h0,        32'h0,        0,  1'b0);
    run_txn("lw_to",    4, 32'h10000000, 32'h0,        32'h0,        20, 1'b0);
    reset_mid_access();
    run_txn("lh_exc",   2, 32'h10000000, 32'h0,        32'h0000ABCD, 0,  1'b1);
    run_txn("lw_after", 4, 32'h10000008, 32'h0,        32'hDEADBEEF, 0,  1'b0);
    run_txn("sh_mis",   6, 32'h10000001, 32'h0000BEEF, 32'h0,        0,  1'b0);
    run_txn("sw_wait",  7, 32'h20000004, 32'hCAFEF00D, 32'h0,        3,  1'b0);

    for (int i = 0; i < 60; i++) begin
      op    = $urandom_range(0, 7);
      addr  = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : 0);
      waits = $urandom_range(0, 9);
      waits = (waits == 9) ? 20 : waits % 4;
      excpt = ($urandom_range(0, 7) == 0);
      run_txn("rand", op, addr, $urandom, $urandom, waits, excpt);
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
